// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths, latency default and FSM encoding for mem_arbiter
package mem_arbiter_pkg;

    localparam int ADDR_W      = 13;
    localparam int DATA_W      = 32;
    localparam int LATENCY_DEF = 2;
    localparam int CNT_W       = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - two-way round-robin grant with last-grant register
module arb_rr2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] grant
);

    // req[0] is fetch, req[1] is data; last_data=0 means data wins the next tie
    logic last_data;

    // on contention grant the side that did not win last time
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_data ? 2'b01 : 2'b10;
        end
    end

    // remember the winner only when the grant is actually accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            last_data <= 1'b0;
        end else if (take && (grant != 2'b00)) begin
            last_data <= grant[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of a shared single-port memory
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               gnt_data;
    logic               lat_wr;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;
    logic               flushed;
    logic               in_idle;
    logic [1:0]         grant;

    assign in_idle = (state == IDLE);

    // a flush in the grant cycle simply hides the fetch request from the arbiter
    arb_rr2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .req   ({d_req, if_req & ~if_flush}),
        .take  (in_idle),
        .grant (grant)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant != 2'b00) state_nx = ACCESS;
            ACCESS:  if (cnt == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // memory port is driven only while accessing, from the latched request
    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == ACCESS) begin
            mem_en    = 1'b1;
            mem_wr    = gnt_data & lat_wr;
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
        end
    end

    // a fetch flushed at any point after grant still finishes on memory but is never acked
    assign if_ack   = (state == DONE) & ~gnt_data & ~flushed & ~if_flush;
    assign d_ack    = (state == DONE) & gnt_data;
    assign if_stall = if_req & ~if_ack;
    assign d_stall  = d_req & ~d_ack;

    // request latch, access counter and per-side read data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            gnt_data  <= 1'b0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            flushed   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        gnt_data  <= grant[1];
                        lat_wr    <= grant[1] & d_wr;
                        lat_addr  <= grant[1] ? d_addr : if_addr;
                        lat_wdata <= grant[1] ? d_wdata : '0;
                        cnt       <= CNT_W'(LATENCY - 1);
                        flushed   <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (~gnt_data & if_flush) flushed <= 1'b1;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (gnt_data) begin
                        d_rdata <= mem_rdata;
                    end else begin
                        if_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and random checks of mem_arbiter against a transaction model
module tb_mem_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_ack, if_stall;
    logic [12:0] if_addr;
    logic [31:0] if_rdata;
    logic        d_req, d_wr, d_ack, d_stall;
    logic [12:0] d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        mem_en, mem_wr;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] dev_mem [0:8191];
    logic [31:0] ref_mem [0:8191];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = dev_mem[mem_addr];

    always @(posedge clk) begin
        if (mem_en && mem_wr) dev_mem[mem_addr] <= mem_wdata;
    end

    // transaction-level model state
    int          cyc = 0;
    bit          busy = 0;
    int          g_cyc;
    bit          g_data, g_wr, g_flushed;
    logic [12:0] g_addr;
    logic [31:0] g_wdata;
    bit          last_data = 0;
    logic [31:0] m_if_rdata = '0, m_d_rdata = '0;
    bit          m_d_known = 1;

    // requester state
    bit          f_pend = 0, d_pend = 0, dv_wr = 0;
    logic [12:0] f_addr = '0, dv_addr = '0;
    logic [31:0] dv_wdata = '0;
    bit          ack_if_seen = 0, ack_d_seen = 0;
    int          ack_cyc_q[$];
    bit          ack_side_q[$];
    int          t0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic cycle_step();
        bit in_acc, ack_cyc, e_if_ack, e_d_ack, e_wr, fr, dr;
        #1;
        in_acc  = busy && (cyc > g_cyc) && (cyc <= g_cyc + L);
        ack_cyc = busy && (cyc == g_cyc + L + 1);
        if (busy && !g_data && if_flush && (cyc > g_cyc)) g_flushed = 1;
        e_if_ack = ack_cyc && !g_data && !g_flushed;
        e_d_ack  = ack_cyc && g_data;
        e_wr     = in_acc && g_data && g_wr;
        chk("if_ack", 32'(if_ack), 32'(e_if_ack));
        chk("d_ack", 32'(d_ack), 32'(e_d_ack));
        chk("mem_en", 32'(mem_en), 32'(in_acc));
        chk("mem_wr", 32'(mem_wr), 32'(e_wr));
        if (in_acc) chk("mem_addr", 32'(mem_addr), 32'(g_addr));
        if (e_wr) chk("mem_wdata", mem_wdata, g_wdata);
        chk("if_stall", 32'(if_stall), 32'(if_req & ~e_if_ack));
        chk("d_stall", 32'(d_stall), 32'(d_req & ~e_d_ack));
        chk("if_rdata_hold", if_rdata, m_if_rdata);
        if (m_d_known) chk("d_rdata_hold", d_rdata, m_d_rdata);
        ack_if_seen = (if_ack === 1'b1);
        ack_d_seen  = (d_ack === 1'b1);
        if (ack_if_seen) begin ack_cyc_q.push_back(cyc); ack_side_q.push_back(1'b0); end
        if (ack_d_seen)  begin ack_cyc_q.push_back(cyc); ack_side_q.push_back(1'b1); end
        if (e_wr) ref_mem[g_addr] = g_wdata;
        if (rst) begin
            busy = 0; last_data = 0; m_if_rdata = '0; m_d_rdata = '0; m_d_known = 1;
        end else begin
            if (busy && (cyc == g_cyc + L)) begin
                if (!g_data) m_if_rdata = ref_mem[g_addr];
                else if (g_wr) m_d_known = 0;
                else begin m_d_rdata = ref_mem[g_addr]; m_d_known = 1; end
            end
            if (ack_cyc) begin
                busy = 0;
            end else if (!busy) begin
                fr = if_req && !if_flush;
                dr = d_req;
                if (fr || dr) begin
                    g_data    = dr && (!fr || !last_data);
                    last_data = g_data;
                    busy      = 1;
                    g_cyc     = cyc;
                    g_flushed = 0;
                    g_wr      = g_data && d_wr;
                    g_addr    = g_data ? d_addr : if_addr;
                    g_wdata   = d_wdata;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // mode 0: finish outstanding only, 1: random new requests, 2: re-request on every ack
    task automatic drive(input int mode);
        if (ack_if_seen) f_pend = (mode == 2);
        if (ack_d_seen)  d_pend = (mode == 2);
        if (mode == 1) begin
            if (!f_pend && ($urandom_range(0, 2) == 0)) begin
                f_pend = 1;
                f_addr = $urandom_range(0, 1) ? 13'($urandom_range(0, 15)) : 13'($urandom);
            end
            if (!d_pend && ($urandom_range(0, 2) == 0)) begin
                d_pend   = 1;
                dv_wr    = 1'($urandom);
                dv_addr  = $urandom_range(0, 1) ? 13'($urandom_range(0, 15)) : 13'($urandom);
                dv_wdata = $urandom;
            end
        end
        if_req  = f_pend;
        if_addr = f_pend ? f_addr : 13'($urandom);
        d_req   = d_pend;
        d_wr    = d_pend ? dv_wr : 1'($urandom);
        d_addr  = d_pend ? dv_addr : 13'($urandom);
        d_wdata = d_pend ? dv_wdata : $urandom;
    endtask

    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            drive(mode);
            cycle_step();
        end
    endtask

    function automatic int first_ack_cyc();
        return (ack_cyc_q.size() > 0) ? ack_cyc_q[0] - t0 : -1;
    endfunction

    initial begin
        for (int i = 0; i < 8192; i++) begin
            dev_mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
            ref_mem[i] = dev_mem[i];
        end
        dev_mem[13'h010] = 32'h1234_5678;
        ref_mem[13'h010] = 32'h1234_5678;
        rst = 1; if_req = 0; if_addr = '0; if_flush = 0;
        d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
        @(posedge clk);
        #1;
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_acks", 32'({if_ack, d_ack}), 32'd0);
        cycle_step();
        rst = 0;

        // single fetch read
        ack_cyc_q.delete(); ack_side_q.delete();
        f_pend = 1; f_addr = 13'h010; t0 = cyc;
        run(8, 0);
        chk("fetch_ack_cycle", 32'(first_ack_cyc()), 32'd3);
        chk("fetch_rdata", if_rdata, 32'h1234_5678);

        // data write to the top address, then read it back
        ack_cyc_q.delete(); ack_side_q.delete();
        d_pend = 1; dv_wr = 1; dv_addr = 13'h1FFF; dv_wdata = 32'hDEAD_BEEF; t0 = cyc;
        run(8, 0);
        chk("write_ack_cycle", 32'(first_ack_cyc()), 32'd3);
        d_pend = 1; dv_wr = 0;
        run(8, 0);
        chk("readback", d_rdata, 32'hDEAD_BEEF);

        // both requests held from reset: D, I, D, I at 4-cycle spacing
        rst = 1; f_pend = 1; f_addr = 13'h004; d_pend = 1; dv_wr = 0; dv_addr = 13'h008;
        drive(2);
        cycle_step();
        rst = 0;
        ack_cyc_q.delete(); ack_side_q.delete(); t0 = cyc;
        run(16, 2);
        chk("rr_count", 32'(ack_cyc_q.size()), 32'd4);
        for (int i = 0; i < ack_cyc_q.size() && i < 4; i++) begin
            chk($sformatf("rr_side%0d", i), 32'(ack_side_q[i]), 32'(i % 2 == 0));
            chk($sformatf("rr_cycle%0d", i), 32'(ack_cyc_q[i] - t0), 32'(3 + 4 * i));
        end
        run(8, 0);

        // flush during the first access cycle of a fetch: no ack, then re-request completes
        ack_cyc_q.delete(); ack_side_q.delete();
        f_pend = 1; f_addr = 13'h020; t0 = cyc;
        run(1, 0);
        if_flush = 1;
        run(1, 0);
        if_flush = 0;
        run(10, 0);
        chk("flush_reack_cycle", 32'(first_ack_cyc()), 32'd7);

        // flush in the grant cycle with both requesting: data wins
        ack_cyc_q.delete(); ack_side_q.delete();
        f_pend = 1; f_addr = 13'h030; d_pend = 1; dv_wr = 0; dv_addr = 13'h005;
        if_flush = 1;
        run(1, 0);
        if_flush = 0;
        run(12, 0);
        chk("idle_flush_first_side", 32'((ack_side_q.size() > 0) ? ack_side_q[0] : 1'b0), 32'd1);

        // reset on the second access cycle: idle next cycle, never acked
        ack_cyc_q.delete(); ack_side_q.delete();
        f_pend = 1; f_addr = 13'h040;
        run(2, 0);
        rst = 1;
        run(1, 0);
        rst = 0; f_pend = 0;
        drive(0);
        chk("rst_mid_mem_en", 32'(mem_en), 32'd0);
        run(8, 0);
        chk("rst_mid_no_ack", 32'(ack_cyc_q.size()), 32'd0);

        // random traffic
        run(600, 1);
        run(12, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
